tile_buffer_controller: RTL and testbench

- Responder side of the tile buffer interface used by the execution units: GEMV and the other ops issue vector/matrix tile reads and vector tile writes by buffer id only, with no address.
- Holds NUM_BUFFERS independent tile buffers, each with its own write pointer, fill level and auto-incrementing read pointer.
- Returns each requested tile one cycle after the request, with a valid pulse.
- Sits between the execution units and on-chip SRAM; the load/store unit writes through the same write port.

---
 rtl/tile_buffer_controller.sv | 179 +++++++++++++++++
 tb/tb_tile_buffer_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_buffer_controller.sv
// tile_buffer_controller
//   Responder for execution-unit tile traffic. Holds NUM_BUFFERS tile buffers,
//   each addressed only by buffer id. Writes append a tile. Reads replay the
//   stored tiles cyclically through an auto-incrementing read pointer. Both read
//   ports return registered data one cycle after the request.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   vec_read_*               vector read port: enable + id in, tile + valid out
//   mat_read_*               matrix read port: enable + id in, tile + valid out
//   vec_write_*              append port shared with the load/store unit
//   rewind_enable            read pointer of rewind_buffer_id goes to 0
//   clear_enable             empties rewind_buffer_id; has priority over rewind
//   err_underflow            sticky: read of an empty buffer
//   err_overflow             sticky: write to a full buffer
//   err_bad_id               sticky: any access with id >= NUM_BUFFERS
//
// Per-buffer fill state
//   state       | meaning
//   ST_EMPTY    | level == 0; reads return zeros and rd_ptr is held
//   ST_FILLING  | 0 < level < DEPTH
//   ST_FULL     | level == DEPTH; further writes are dropped
module tile_buffer_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_ELEMS  = 32,
  parameter int NUM_BUFFERS = 4,
  parameter int DEPTH       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vec_read_enable,
  input  logic [4:0]                             vec_read_buffer_id,
  output logic signed [DATA_WIDTH*TILE_ELEMS-1:0] vec_read_tile,
  output logic                                   vec_read_valid,
  input  logic                                   mat_read_enable,
  input  logic [4:0]                             mat_read_buffer_id,
  output logic signed [DATA_WIDTH*TILE_ELEMS-1:0] mat_read_tile,
  output logic                                   mat_read_valid,
  input  logic                                   vec_write_enable,
  input  logic [4:0]                             vec_write_buffer_id,
  input  logic signed [DATA_WIDTH*TILE_ELEMS-1:0] vec_write_tile,
  input  logic                                   rewind_enable,
  input  logic                                   clear_enable,
  input  logic [4:0]                             rewind_buffer_id,
  output logic                                   err_underflow,
  output logic                                   err_overflow,
  output logic                                   err_bad_id
);

  localparam int TW = DATA_WIDTH * TILE_ELEMS;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

  localparam logic [4:0]    NB_ID    = 5'(NUM_BUFFERS);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]    state_q  [NUM_BUFFERS];
  logic [LW-1:0] level_q  [NUM_BUFFERS];
  logic [IW-1:0] rd_ptr_q [NUM_BUFFERS];
  logic [1:0]    state_d  [NUM_BUFFERS];
  logic [LW-1:0] level_d  [NUM_BUFFERS];
  logic [IW-1:0] rd_ptr_d [NUM_BUFFERS];

  logic signed [TW-1:0] mem [NUM_BUFFERS][DEPTH];

  // Next replay position: wraps at the current fill level, not at DEPTH.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p,
                                             input logic [LW-1:0] lvl);
    if (LW'(p) + LW'(1) == lvl) return '0;
    return p + IW'(1);
  endfunction

  logic          vr_ok, mr_ok, wr_ok, rc_ok, rc_req;
  logic [BW-1:0] vr_b, mr_b, wr_b, rc_b;
  logic          v_empty, m_empty, same_buf;
  logic [IW-1:0] v_pos, m_pos;
  logic          clr_hits_wr, mem_we, wr_full;
  logic [IW-1:0] mem_widx;

  assign vr_b   = vec_read_buffer_id[BW-1:0];
  assign mr_b   = mat_read_buffer_id[BW-1:0];
  assign wr_b   = vec_write_buffer_id[BW-1:0];
  assign rc_b   = rewind_buffer_id[BW-1:0];
  assign rc_req = rewind_enable | clear_enable;

  assign vr_ok = vec_read_enable  && (vec_read_buffer_id  < NB_ID);
  assign mr_ok = mat_read_enable  && (mat_read_buffer_id  < NB_ID);
  assign wr_ok = vec_write_enable && (vec_write_buffer_id < NB_ID);
  assign rc_ok = rc_req           && (rewind_buffer_id    < NB_ID);

  assign v_empty  = (state_q[vr_b] == ST_EMPTY);
  assign m_empty  = (state_q[mr_b] == ST_EMPTY);
  assign same_buf = vr_ok && mr_ok && (vr_b == mr_b);

  // When both ports hit one buffer the matrix port takes the slot after the
  // vector port's, so the pair consumes two consecutive tiles.
  assign v_pos = rd_ptr_q[vr_b];
  assign m_pos = same_buf ? wrap_inc(rd_ptr_q[mr_b], level_q[mr_b]) : rd_ptr_q[mr_b];

  // A clear landing with a write restarts the buffer with that tile at index 0.
  assign clr_hits_wr = clear_enable && rc_ok && (rc_b == wr_b);
  assign wr_full     = (state_q[wr_b] == ST_FULL);
  assign mem_we      = wr_ok && (clr_hits_wr || !wr_full) && !rst;
  // The write pointer always equals the fill level, so it is derived from it.
  assign mem_widx    = clr_hits_wr ? '0 : level_q[wr_b][IW-1:0];

  always_comb begin
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      state_d[b]  = state_q[b];
      level_d[b]  = level_q[b];
      rd_ptr_d[b] = rd_ptr_q[b];

      if (state_q[b] != ST_EMPTY) begin
        if (vr_ok && (vr_b == BW'(b))) rd_ptr_d[b] = wrap_inc(rd_ptr_d[b], level_q[b]);
        if (mr_ok && (mr_b == BW'(b))) rd_ptr_d[b] = wrap_inc(rd_ptr_d[b], level_q[b]);
      end

      if (rc_ok && (rc_b == BW'(b))) rd_ptr_d[b] = '0;

      if (rc_ok && clear_enable && (rc_b == BW'(b))) begin
        if (wr_ok && (wr_b == BW'(b))) begin
          level_d[b] = LW'(1);
          state_d[b] = (FULL_LVL == LW'(1)) ? ST_FULL : ST_FILLING;
        end else begin
          level_d[b] = '0;
          state_d[b] = ST_EMPTY;
        end
      end else if (wr_ok && (wr_b == BW'(b)) && (state_q[b] != ST_FULL)) begin
        level_d[b] = level_q[b] + LW'(1);
        state_d[b] = (level_q[b] + LW'(1) == FULL_LVL) ? ST_FULL : ST_FILLING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        state_q[b]  <= ST_EMPTY;
        level_q[b]  <= '0;
        rd_ptr_q[b] <= '0;
      end
      vec_read_valid <= 1'b0;
      mat_read_valid <= 1'b0;
      vec_read_tile  <= '0;
      mat_read_tile  <= '0;
      err_underflow  <= 1'b0;
      err_overflow   <= 1'b0;
      err_bad_id     <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        state_q[b]  <= state_d[b];
        level_q[b]  <= level_d[b];
        rd_ptr_q[b] <= rd_ptr_d[b];
      end
      vec_read_valid <= vec_read_enable;
      mat_read_valid <= mat_read_enable;
      vec_read_tile  <= (vr_ok && !v_empty) ? mem[vr_b][v_pos] : '0;
      mat_read_tile  <= (mr_ok && !m_empty) ? mem[mr_b][m_pos] : '0;
      if ((vr_ok && v_empty) || (mr_ok && m_empty))
        err_underflow <= 1'b1;
      if (wr_ok && wr_full && !clr_hits_wr)
        err_overflow <= 1'b1;
      if ((vec_read_enable && !vr_ok) || (mat_read_enable && !mr_ok) ||
          (vec_write_enable && !wr_ok) || (rc_req && !rc_ok))
        err_bad_id <= 1'b1;
    end
  end

  // Tile storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_b][mem_widx] <= vec_write_tile;
  end

endmodule

// File: tb/tb_tile_buffer_controller.sv
module tb_tile_buffer_controller;
  localparam int DW = 8, TE = 32, NB = 4, DEPTH = 16, TW = DW * TE;

  logic clk = 1'b0;
  logic rst;
  logic vec_read_enable, mat_read_enable, vec_write_enable;
  logic rewind_enable, clear_enable;
  logic [4:0] vec_read_buffer_id, mat_read_buffer_id, vec_write_buffer_id, rewind_buffer_id;
  logic signed [TW-1:0] vec_read_tile, mat_read_tile, vec_write_tile;
  logic vec_read_valid, mat_read_valid;
  logic err_underflow, err_overflow, err_bad_id;

  always #5 clk = ~clk;

  tile_buffer_controller #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .NUM_BUFFERS(NB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .vec_read_enable(vec_read_enable), .vec_read_buffer_id(vec_read_buffer_id),
    .vec_read_tile(vec_read_tile), .vec_read_valid(vec_read_valid),
    .mat_read_enable(mat_read_enable), .mat_read_buffer_id(mat_read_buffer_id),
    .mat_read_tile(mat_read_tile), .mat_read_valid(mat_read_valid),
    .vec_write_enable(vec_write_enable), .vec_write_buffer_id(vec_write_buffer_id),
    .vec_write_tile(vec_write_tile),
    .rewind_enable(rewind_enable), .clear_enable(clear_enable),
    .rewind_buffer_id(rewind_buffer_id),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_bad_id(err_bad_id)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each buffer is a list of stored tiles plus a replay index.
  int           lvl [NB];
  int           rp  [NB];
  logic [TW-1:0] mm [NB][DEPTH];
  logic          e_vv, e_mv, e_uf, e_of, e_bad;
  logic [TW-1:0] e_vt, e_mt;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tile(input int e0);
    logic [TW-1:0] t;
    for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
    t[DW-1:0] = DW'(e0);
    return t;
  endfunction

  task automatic model_step();
    int vid, mid, wid, cid;
    bit same;
    vid = int'(vec_read_buffer_id);
    mid = int'(mat_read_buffer_id);
    wid = int'(vec_write_buffer_id);
    cid = int'(rewind_buffer_id);
    if (rst) begin
      e_vv = 0; e_mv = 0; e_uf = 0; e_of = 0; e_bad = 0; e_vt = '0; e_mt = '0;
      for (int b = 0; b < NB; b++) begin lvl[b] = 0; rp[b] = 0; end
      return;
    end
    e_vv = vec_read_enable;
    e_mv = mat_read_enable;
    e_vt = '0;
    e_mt = '0;
    same = vec_read_enable && mat_read_enable && (vid == mid) && (vid < NB);
    if (vec_read_enable) begin
      if (vid >= NB) e_bad = 1;
      else if (lvl[vid] == 0) e_uf = 1;
      else e_vt = mm[vid][rp[vid]];
    end
    if (mat_read_enable) begin
      if (mid >= NB) e_bad = 1;
      else if (lvl[mid] == 0) e_uf = 1;
      else e_mt = mm[mid][(rp[mid] + (same ? 1 : 0)) % lvl[mid]];
    end
    if (vec_read_enable && vid < NB && lvl[vid] > 0) rp[vid] = (rp[vid] + 1) % lvl[vid];
    if (mat_read_enable && mid < NB && lvl[mid] > 0) rp[mid] = (rp[mid] + 1) % lvl[mid];
    if (rewind_enable || clear_enable) begin
      if (cid >= NB) e_bad = 1;
      else begin
        rp[cid] = 0;
        if (clear_enable) lvl[cid] = 0;
      end
    end
    if (vec_write_enable) begin
      if (wid >= NB) e_bad = 1;
      else if (lvl[wid] < DEPTH) begin
        mm[wid][lvl[wid]] = vec_write_tile;
        lvl[wid]++;
      end else e_of = 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("vec_valid", TW'(vec_read_valid), TW'(e_vv));
    chk("mat_valid", TW'(mat_read_valid), TW'(e_mv));
    if (e_vv) chk("vec_tile", vec_read_tile, e_vt);
    if (e_mv) chk("mat_tile", mat_read_tile, e_mt);
    chk("err_underflow", TW'(err_underflow), TW'(e_uf));
    chk("err_overflow", TW'(err_overflow), TW'(e_of));
    chk("err_bad_id", TW'(err_bad_id), TW'(e_bad));
  endtask

  task automatic idle();
    rst = 0;
    vec_read_enable = 0; mat_read_enable = 0; vec_write_enable = 0;
    rewind_enable = 0; clear_enable = 0;
    vec_read_buffer_id = '0; mat_read_buffer_id = '0;
    vec_write_buffer_id = '0; rewind_buffer_id = '0;
    vec_write_tile = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); cycle(); idle();
  endtask

  task automatic wr(input int id, input int e0);
    idle();
    vec_write_enable = 1; vec_write_buffer_id = 5'(id); vec_write_tile = mk_tile(e0);
    cycle();
  endtask

  task automatic rd_v(input int id);
    idle(); vec_read_enable = 1; vec_read_buffer_id = 5'(id);
    cycle();
  endtask

  task automatic lit8(input string name, input logic [DW-1:0] act, input int exp);
    chk(name, TW'(act), TW'(DW'(exp)));
  endtask

  int exp1 [4] = '{1, 2, 3, 1};

  function automatic int rid();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(NB, 31));
    return int'($urandom_range(0, NB - 1));
  endfunction

  initial begin
    idle();
    do_reset();
    chk("lit_reset_vvalid", TW'(vec_read_valid), '0);
    chk("lit_reset_mvalid", TW'(mat_read_valid), '0);
    chk("lit_reset_errs", TW'({err_underflow, err_overflow, err_bad_id}), '0);

    // cyclic replay at level 3
    wr(1, 1); wr(1, 2); wr(1, 3);
    for (int i = 0; i < 4; i++) begin
      rd_v(1);
      chk("lit_replay_valid", TW'(vec_read_valid), TW'(1'b1));
      lit8("lit_replay_e0", vec_read_tile[DW-1:0], exp1[i]);
    end

    // empty read
    rd_v(2);
    chk("lit_empty_valid", TW'(vec_read_valid), TW'(1'b1));
    chk("lit_empty_tile", vec_read_tile, '0);
    chk("lit_empty_flags", TW'({err_underflow, err_overflow, err_bad_id}), TW'(3'b100));

    // fill to DEPTH and overflow
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(0, i);
      if (i == DEPTH - 1) chk("lit_no_overflow_yet", TW'(err_overflow), '0);
    end
    chk("lit_overflow", TW'(err_overflow), TW'(1'b1));
    for (int i = 0; i < DEPTH; i++) begin
      rd_v(0);
      lit8("lit_full_order", vec_read_tile[DW-1:0], i);
    end

    // dual read of one buffer
    wr(3, 10); wr(3, 20); wr(3, 30);
    idle();
    vec_read_enable = 1; vec_read_buffer_id = 5'd3;
    mat_read_enable = 1; mat_read_buffer_id = 5'd3;
    cycle();
    lit8("lit_dual_vec", vec_read_tile[DW-1:0], 10);
    lit8("lit_dual_mat", mat_read_tile[DW-1:0], 20);
    rd_v(3);
    lit8("lit_dual_next", vec_read_tile[DW-1:0], 30);

    // rewind concurrent with read
    wr(1, 1); wr(1, 2); wr(1, 3);
    rd_v(1);
    lit8("lit_rw_first", vec_read_tile[DW-1:0], 1);
    idle();
    vec_read_enable = 1; vec_read_buffer_id = 5'd1;
    rewind_enable = 1; rewind_buffer_id = 5'd1;
    cycle();
    lit8("lit_rw_with_read", vec_read_tile[DW-1:0], 2);
    rd_v(1);
    lit8("lit_rw_after", vec_read_tile[DW-1:0], 1);

    // bad ids, then clear with concurrent write
    idle();
    vec_read_enable = 1; vec_read_buffer_id = 5'd7;
    vec_write_enable = 1; vec_write_buffer_id = 5'd9; vec_write_tile = mk_tile(99);
    cycle();
    chk("lit_bad_valid", TW'(vec_read_valid), TW'(1'b1));
    chk("lit_bad_tile", vec_read_tile, '0);
    chk("lit_bad_flag", TW'(err_bad_id), TW'(1'b1));
    idle();
    clear_enable = 1; rewind_enable = 1; rewind_buffer_id = 5'd1;
    vec_write_enable = 1; vec_write_buffer_id = 5'd1; vec_write_tile = mk_tile(5);
    cycle();
    rd_v(1);
    lit8("lit_clear_wr_1", vec_read_tile[DW-1:0], 5);
    rd_v(1);
    lit8("lit_clear_wr_2", vec_read_tile[DW-1:0], 5);

    // read issued during reset
    idle(); rst = 1; vec_read_enable = 1; vec_read_buffer_id = 5'd0;
    cycle();
    chk("lit_reset_read", TW'(vec_read_valid), '0);
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 499) == 0);
      vec_read_enable  = ($urandom_range(0, 9) < 4);
      vec_read_buffer_id = 5'(rid());
      mat_read_enable  = ($urandom_range(0, 9) < 4);
      mat_read_buffer_id = ($urandom_range(0, 3) == 0) ? vec_read_buffer_id : 5'(rid());
      vec_write_enable = ($urandom_range(0, 9) < 5);
      vec_write_buffer_id = 5'(rid());
      vec_write_tile   = mk_tile(int'($urandom_range(0, 255)));
      rewind_enable    = ($urandom_range(0, 99) < 5);
      clear_enable     = ($urandom_range(0, 99) < 3);
      rewind_buffer_id = ($urandom_range(0, 3) == 0) ? vec_write_buffer_id : 5'(rid());
      cycle();
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
